// File: rtl/uart_rx_fifo.sv
// UART receive buffer: parity check, show-ahead FIFO,
// sticky overflow flag and saturating parity-error count.
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int PARITY_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_parity,
  input  logic              in_en,
  output logic [7:0]        out_data,
  output logic              out_perr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic [7:0]        perr_cnt
);

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  logic [8:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        pcnt_q, pcnt_d;
  logic              perr;
  logic              rd;
  logic              wr;
  logic              is_full;
  logic              is_empty;

  always_comb begin
    perr = 1'b0;
    if (PARITY_MODE == 0) begin
      perr = ^{in_data, in_parity};
    end else if (PARITY_MODE == 1) begin
      perr = ~^{in_data, in_parity};
    end
  end

  assign is_full  = (count_q == FULL_CNT);
  assign is_empty = (count_q == '0);
  assign rd       = !is_empty && out_ready;
  // A full FIFO still takes a byte when the head leaves this cycle.
  assign wr       = in_en && (!is_full || rd);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    pcnt_d  = pcnt_q;
    if (wr) begin
      wptr_d = wptr_q + ADDR_W'(1);
    end
    if (rd) begin
      rptr_d = rptr_q + ADDR_W'(1);
    end
    if (wr && !rd) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end else if (rd && !wr) begin
      count_d = count_q - (ADDR_W+1)'(1);
    end
    if (in_en && !wr) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end
    if (wr && perr && (pcnt_q != 8'hFF)) begin
      pcnt_d = pcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      pcnt_q  <= 8'h00;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      pcnt_q  <= pcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !rst) begin
      mem_q[wptr_q] <= {perr, in_data};
    end
  end

  always_comb begin
    out_data = 8'h00;
    out_perr = 1'b0;
    if (!is_empty) begin
      out_data = mem_q[rptr_q][7:0];
      out_perr = mem_q[rptr_q][8];
    end
  end

  assign out_valid = !is_empty;
  assign count     = count_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign overflow  = ovf_q;
  assign perr_cnt  = pcnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus random stimulus for uart_rx_fifo,
// checked against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_parity;
  logic       in_en;
  logic [7:0] out_data;
  logic       out_perr;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clr_overflow;
  logic [7:0] perr_cnt;

  uart_rx_fifo #(
    .DEPTH(16), .ADDR_W(4), .PARITY_MODE(0)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_parity(in_parity), .in_en(in_en),
    .out_data(out_data), .out_perr(out_perr),
    .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty),
    .overflow(overflow), .clr_overflow(clr_overflow),
    .perr_cnt(perr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] mq[$];
  logic       m_ovf;
  int         m_pcnt;
  int         vecs;
  int         fails;
  logic [7:0] popped[$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] ed;
    logic       ep;
    ed = 8'h00;
    ep = 1'b0;
    if (mq.size() != 0) begin
      ed = mq[0][7:0];
      ep = mq[0][8];
    end
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("out_data", 32'(out_data), 32'(ed));
    check("out_perr", 32'(out_perr), 32'(ep));
    check("count", 32'(count), 32'(mq.size()));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("perr_cnt", 32'(perr_cnt), 32'(m_pcnt));
  endtask

  // Drive one cycle, advance the model, then check after the edge.
  task automatic cyc(input logic r, input logic en,
                     input logic [7:0] d, input logic p,
                     input logic rdy, input logic clr);
    logic rdo;
    logic wro;
    logic pe;
    rst = r;
    in_en = en;
    in_data = d;
    in_parity = p;
    out_ready = rdy;
    clr_overflow = clr;
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_pcnt = 0;
    end else begin
      pe = ^{d, p};
      rdo = (mq.size() != 0) && rdy;
      wro = en && ((mq.size() < DEPTH) || rdo);
      if (rdo) popped.push_back(mq.pop_front() & 9'h0FF);
      if (wro) mq.push_back({pe, d});
      if (wro && pe && m_pcnt < 255) m_pcnt++;
      if (en && !wro) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  function automatic logic par(input logic [7:0] d);
    return ^d;
  endfunction

  initial begin
    vecs = 0;
    fails = 0;
    m_ovf = 1'b0;
    m_pcnt = 0;
    rst = 1'b1;
    in_en = 1'b0;
    in_data = 8'h00;
    in_parity = 1'b0;
    out_ready = 1'b0;
    clr_overflow = 1'b0;
    @(negedge clk);

    cyc(1, 0, 8'h00, 0, 0, 0);
    cyc(1, 0, 8'h00, 0, 0, 0);
    check("rst_empty", 32'(empty), 32'd1);

    cyc(0, 1, 8'hA5, 0, 0, 0);
    check("a5_data", 32'(out_data), 32'hA5);
    check("a5_count", 32'(count), 32'd1);
    cyc(0, 0, 8'h00, 0, 1, 0);
    check("a5_drained", 32'(out_valid), 32'd0);

    cyc(0, 1, 8'h01, 0, 0, 0);
    check("perr_flag", 32'(out_perr), 32'd1);
    check("perr_cnt1", 32'(perr_cnt), 32'd1);
    for (int i = 0; i < 300; i++) cyc(0, 1, 8'h01, 0, 1, 0);
    check("perr_sat", 32'(perr_cnt), 32'hFF);
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 0, 1, 0);

    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 8'(i), par(8'(i)), 0, 0);
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    cyc(0, 1, 8'h10, par(8'h10), 0, 0);
    check("drop_ovf", 32'(overflow), 32'd1);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check("clr_ovf", 32'(overflow), 32'd0);
    cyc(0, 1, 8'h55, par(8'h55), 1, 0);
    check("fullrw_cnt", 32'(count), 32'd16);
    check("fullrw_ovf", 32'(overflow), 32'd0);
    cyc(0, 1, 8'h77, par(8'h77), 0, 1);
    check("setwins", 32'(overflow), 32'd1);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check("clr_alone", 32'(overflow), 32'd0);
    popped.delete();
    for (int i = 0; i < 16; i++) cyc(0, 0, 8'h00, 0, 1, 0);
    check("drain_n", 32'(popped.size()), 32'd16);
    for (int i = 0; i < 15; i++) begin
      check("drain_seq", 32'(popped[i]), 32'(i + 1));
    end
    check("drain_last", 32'(popped[15]), 32'h55);

    for (int i = 0; i < 5; i++) cyc(0, 1, 8'(i + 8'h20), 0, 0, 0);
    cyc(1, 1, 8'h99, 0, 0, 0);
    check("rst_cnt", 32'(count), 32'd0);
    check("rst_pcnt", 32'(perr_cnt), 32'd0);
    cyc(0, 1, 8'h3C, par(8'h3C), 0, 0);
    check("sole_3c", 32'(out_data), 32'h3C);
    check("sole_cnt", 32'(count), 32'd1);
    cyc(0, 0, 8'h00, 0, 1, 0);

    popped.delete();
    for (int i = 0; i < 40; i++) begin
      cyc(0, 1, 8'(8'h80 + i), par(8'(8'h80 + i)), 1, 0);
    end
    cyc(0, 0, 8'h00, 0, 1, 0);
    check("stream_n", 32'(popped.size()), 32'd40);
    for (int i = 0; i < 40; i++) begin
      check("stream_seq", 32'(popped[i]), 32'(8'h80 + i));
    end

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 2) != 0),
          8'($urandom),
          1'($urandom),
          ($urandom_range(0, 3) < 2 + (i / 1000 % 2)),
          ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer that sits directly downstream of the UART receiver.
- Accepts the receiver's one-cycle byte strobe with its data byte and sampled parity bit, checks parity, and stores byte plus error flag in a synchronous FIFO.
- Presents entries to the consumer over a show-ahead valid/ready interface.
- Flags overflow when the consumer falls behind and keeps a saturating count of parity errors.

Parameters:
- DEPTH, 16: number of FIFO entries; power of two, minimum 2.
- ADDR_W, 4: log2(DEPTH).
- PARITY_MODE, 0: 0 = even parity, 1 = odd parity, 2 = no check (out_perr always 0).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- in_data  input  8  received byte from UART receiver
- in_parity  input  1  received parity bit
- in_en  input  1  one-cycle strobe; in_data/in_parity valid this cycle
- out_data  output  8  head-of-FIFO byte
- out_perr  output  1  parity error flag of head entry
- out_valid  output  1  head entry present
- out_ready  input  1  consumer accepts head entry
- count  output  ADDR_W+1  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  sticky: a byte was dropped because the FIFO was full
- clr_overflow  input  1  clears overflow
- perr_cnt  output  8  saturating count of parity-error bytes written

Behaviour:
- Reset: one clock is used, clk. Reset rst is synchronous and active-high. When rst is sampled high at a clk edge:
  - read/write pointers and count = 0, empty = 1, full = 0;
  - out_valid = 0, out_data = 8'h00, out_perr = 0;
  - overflow = 0, perr_cnt = 0.
  - Storage contents need not be cleared.
- Reset mid-operation discards all entries. Any in_en in the reset cycle is ignored.
- Parity check (combinational on input):
  - PARITY_MODE 0: perr = ^{in_data, in_parity}.
  - PARITY_MODE 1: perr = ~^{in_data, in_parity}.
  - PARITY_MODE 2: perr = 0.
- Write: in_en = 1 and (not full, or a read occurs the same cycle) stores {perr, in_data} at the write pointer. The write pointer increments modulo DEPTH, wrapping naturally via ADDR_W bits.
- Read: a read occurs when out_valid = 1 and out_ready = 1. The read pointer increments modulo DEPTH.
- Occupancy update:
  - count +1 on write only;
  - count -1 on read only;
  - count unchanged on simultaneous read and write.
- Show-ahead output:
  - out_valid = !empty.
  - out_data/out_perr always reflect the entry at the read pointer.
  - When empty, out_data = 0 and out_perr = 0.
- Latency: byte strobed at edge N appears on out_valid/out_data after edge N, i.e. visible in cycle N+1, if the FIFO was empty.
- Full with simultaneous read: write is accepted, count stays DEPTH, overflow is not set.
- Full without read and in_en = 1:
  - byte is dropped and overflow is set to 1 at that edge;
  - perr_cnt is not incremented for a dropped byte.
- Empty: out_ready is ignored. Simultaneous in_en and out_ready with empty FIFO gives write only; no read.
- overflow:
  - cleared by clr_overflow = 1;
  - if a drop and clr_overflow occur in the same cycle, set wins and overflow = 1.
- perr_cnt: increments by 1 on each accepted write with perr = 1; saturates at 8'hFF with no wrap.
- full/empty/count are registered-state derived and update the cycle after the causing edge.
- in_en is a single-cycle strobe from the receiver. Back-to-back strobes on consecutive cycles are still accepted, each as a separate byte.

Test Plan:
- Reset, then single write in_en with in_data = 8'hA5 and in_parity = 0 (even mode) -> next cycle out_valid = 1, out_data = 8'hA5, out_perr = 0, count = 1. Then out_ready = 1 for one cycle -> out_valid = 0, empty = 1.
- Parity error, even mode: in_data = 8'h01 with in_parity = 0 -> out_perr = 1, perr_cnt = 1. Repeat 300 error bytes while draining -> perr_cnt saturates at 8'hFF.
- Fill 16 bytes 8'h00..8'h0F with out_ready = 0 -> full = 1, count = 16. A 17th byte 8'h10 -> dropped, overflow = 1. Drain all -> sequence 00..0F exactly, no 10.
- Full, with in_en = 1 (8'h55) and out_ready = 1 in the same cycle -> count stays 16, overflow stays 0, 8'h55 read out last.
- Overflow set, then clr_overflow = 1 in the same cycle as another drop -> overflow remains 1. clr_overflow alone next cycle -> overflow = 0.
- Write 5 entries, then assert rst for one cycle while in_en = 1 -> count = 0, out_valid = 0, overflow = 0, perr_cnt = 0. A subsequent write of 8'h3C is read back as the sole entry; pointer wrap is checked by streaming 40 bytes with continuous out_ready and verifying order.
